uart_tx_frame_arbiter: RTL and testbench
========================================

# uart_tx_frame_arbiter

Controller that shares the single UART transmitter among `N_REQ` byte-stream requesters, e.g. the sensor-frame packer and the debug echo path. It grants one requester at a time in round-robin order, at frame granularity. Each granted frame is wrapped as SYNC, source ID, then payload, with an optional XOR checksum. The block sequences the transmitter byte by byte through its `tx_start`/`tx_done` handshake and sits between the requesters and `uart_transmitter` inside `uart_top`, sharing `clk_50MHz`.

## Interface
- `N_REQ`, 2: number of requesters (2..8).
- `DATA_BITS`, 8: byte width; must match the transmitter.
- `SYNC_BYTE`, 8'hA5: first byte of every frame.
- `MAX_LEN`, 16: maximum payload bytes per frame (1..255).
- `clk_50MHz` in 1: system clock; all logic on the rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `req_valid` in N_REQ: per-requester byte available.
- `req_data` in N_REQ*DATA_BITS: requester i occupies bits [i*DATA_BITS +: DATA_BITS].
- `req_last` in N_REQ: qualifies `req_data` as the final payload byte of the frame.
- `req_ready` out N_REQ: one-hot, one-cycle accept pulse; a byte transfers when `req_valid[i] & req_ready[i]`.
- `tx_start` out 1: one-cycle pulse that launches `tx_data` on the transmitter.
- `tx_data` out DATA_BITS: byte to send; held stable from `tx_start` until the matching `tx_done`.
- `tx_done` in 1: one-cycle pulse from the transmitter at the end of the stop bit.
- `busy` out 1: high from grant until the last byte's `tx_done`.
- `grant_id` out clog2(N_REQ): index of the current or last granted requester.
- `truncated` out 1: one-cycle pulse when a frame is closed at `MAX_LEN` without `req_last`.

## Operation
- States: IDLE, SYNC, ID, DATA, CSUM.
- Each non-IDLE state has two phases:
  - launch: assert `tx_start` for one cycle and set `pending`.
  - wait: hold until `tx_done` arrives, then clear `pending` and advance.
- IDLE:
  - If any `req_valid` is high, grant the first valid index after `grant_id`, scanning upward with wrap-around.
  - Load `grant_id` and go to SYNC.
  - `busy` goes high in the same edge.
- SYNC: sends `SYNC_BYTE`. ID: sends the zero-extended `grant_id`.
- DATA:
  - If `req_valid[g]` is high and nothing is pending, pulse `req_ready[g]` and `tx_start` together, with `tx_data = req_data[g]`.
  - Latch `req_last[g]` and increment the length counter.
  - If `req_valid[g]` is low, stall with no timeout. Other requesters are never served mid-frame.
- Leaving DATA after `tx_done` of the current byte:
  - If the latched last flag is set, or the counter equals `MAX_LEN`, go to CSUM if the checksum is compiled in, otherwise to IDLE.
  - If the counter reached `MAX_LEN` without last, pulse `truncated`. The remaining bytes form a new frame after normal arbitration.
- The checksum accumulator holds the XOR of the ID byte and all payload bytes. It clears on grant.
- `busy` falls in the cycle the final `tx_done` is consumed. Re-arbitration happens in IDLE on the following cycle.
- A `tx_done` seen while `pending` is clear is ignored.
- Reset values:
  - State IDLE; `pending`, counter and checksum cleared.
  - All outputs 0, except `grant_id = N_REQ-1`, so requester 0 wins first.
- Reset asserted mid-frame aborts the frame immediately. The transmitter is expected to be reset by the same signal.

## Timing
- `req_valid` high in IDLE (edge k): grant at edge k, SYNC `tx_start` asserted after edge k+1.
- Each `tx_done` at edge k is followed by the next `tx_start` after edge k+1. The one-cycle gap between bytes is fixed.
- Payload `req_ready` coincides exactly with that byte's `tx_start`.
- At 9600 bps a frame of L payload bytes occupies (L+2 or L+3) × 10 bit periods plus one cycle per byte.

## Configuration
- `UART_ARB_CHECKSUM_EN` defined: CSUM state is compiled in and the XOR byte is appended after the payload.
- Undefined: the CSUM state and accumulator are absent, and a frame ends after its last payload byte.

## Structure
- Shared package `uart_pkg`:
  - state encoding constants
  - `SYNC_BYTE` default
  - `DATA_BITS` default
  - clog2 helper
- One sub-module, `rr_arbiter`:
  - inputs: request vector and last-grant index
  - outputs: next grant index and valid flag
  - purely combinational, instantiated once.

## Test plan
- Checksum enabled, requester 1 sends 0x41, 0x42 (last) → TX bytes A5 01 41 42 02; `truncated` stays 0; `busy` falls after the 5th `tx_done`.
- After reset, both requesters valid with single-byte frames 0x10 (req0) and 0x20 (req1) → A5 00 10 then A5 01 20; req0 is served first.
- Requester 0 continuously valid, requester 1 valid once → frames alternate 0, 1, 0; requester 0 never gets two consecutive frames while requester 1 waits.
- `MAX_LEN`=4, requester 0 streams 6 bytes 0x01..0x06 with last on 0x06:
  - `truncated` pulses once after 0x04's `tx_done`.
  - The second frame is A5 00 05 06.
- Reset pulsed during the DATA state of frame 1 → all outputs 0 and `grant_id` = N_REQ-1 within the same cycle; the next frame starts with A5.
- `tx_done` pulsed while in IDLE, and during the stall with `req_valid` low → no state change and no `tx_start`.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame-arbiter state encoding, byte defaults and a clog2 helper.
package uart_pkg;

  localparam int         UART_DATA_BITS = 8;
  localparam logic [7:0] UART_SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SYNC = 3'd1,
    ST_ID   = 3'd2,
    ST_DATA = 3'd3,
    ST_CSUM = 3'd4
  } arb_state_e;

  // Usable in port/parameter widths; returns at least 1 for n >= 2.
  function automatic int uart_clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requester above last_idx (wrapping); combinational, zero latency.
// No backpressure: gnt_vld simply reflects whether any request is present.
module rr_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int GW    = uart_clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [GW-1:0]    last_idx,
  output logic [GW-1:0]    gnt_idx,
  output logic             gnt_vld
);

  logic [GW:0] cand;

  // Scan from the farthest offset down so the nearest requester after last_idx wins.
  always_comb begin
    gnt_idx = '0;
    gnt_vld = 1'b0;
    cand    = '0;
    for (int ofs = N_REQ; ofs >= 1; ofs--) begin
      cand = {1'b0, last_idx} + (GW+1)'(ofs);
      if (cand >= (GW+1)'(N_REQ)) cand = cand - (GW+1)'(N_REQ);
      if (req[cand[GW-1:0]]) begin
        gnt_idx = cand[GW-1:0];
        gnt_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_frame_arbiter.sv
// Frames requester byte streams as SYNC, ID, payload (+ XOR byte when UART_ARB_CHECKSUM_EN) onto one UART TX;
// grant-to-first-tx_start 1 cycle, fixed 1-cycle gap after each tx_done, payload stalls while req_valid[g] is low.
module uart_tx_frame_arbiter
  import uart_pkg::*;
#(
  parameter int                   N_REQ     = 2,
  parameter int                   DATA_BITS = UART_DATA_BITS,
  parameter logic [DATA_BITS-1:0] SYNC_BYTE = DATA_BITS'(UART_SYNC_BYTE),
  parameter int                   MAX_LEN   = 16
) (
  input  logic                          clk_50MHz,
  input  logic                          reset,
  input  logic [N_REQ-1:0]              req_valid,
  input  logic [N_REQ*DATA_BITS-1:0]    req_data,
  input  logic [N_REQ-1:0]              req_last,
  output logic [N_REQ-1:0]              req_ready,
  output logic                          tx_start,
  output logic [DATA_BITS-1:0]          tx_data,
  input  logic                          tx_done,
  output logic                          busy,
  output logic [uart_clog2(N_REQ)-1:0]  grant_id,
  output logic                          truncated
);

  localparam int GW = uart_clog2(N_REQ);
  localparam int LW = uart_clog2(MAX_LEN + 1);

  arb_state_e           state_q, state_d;
  logic                 pending_q, pending_d;
  logic [LW-1:0]        len_q, len_d;
  logic                 last_q, last_d;
  logic [N_REQ-1:0]     req_ready_q, req_ready_d;
  logic                 tx_start_q, tx_start_d;
  logic [DATA_BITS-1:0] tx_data_q, tx_data_d;
  logic                 busy_q, busy_d;
  logic [GW-1:0]        grant_id_q, grant_id_d;
  logic                 truncated_q, truncated_d;
`ifdef UART_ARB_CHECKSUM_EN
  logic [DATA_BITS-1:0] csum_q, csum_d;
`endif

  logic [GW-1:0]        arb_idx;
  logic                 arb_vld;
  logic [DATA_BITS-1:0] sel_data;
  logic                 sel_valid;
  logic                 sel_last;
  logic [DATA_BITS-1:0] id_byte;
  logic                 frame_end;

  rr_arbiter #(.N_REQ(N_REQ), .GW(GW)) u_rr_arbiter (
    .req      (req_valid),
    .last_idx (grant_id_q),
    .gnt_idx  (arb_idx),
    .gnt_vld  (arb_vld)
  );

  assign sel_valid = req_valid[grant_id_q];
  assign sel_last  = req_last[grant_id_q];
  assign id_byte   = DATA_BITS'(grant_id_q);
  assign frame_end = last_q || (len_q == LW'(MAX_LEN));

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_id_q == GW'(i)) sel_data = req_data[i*DATA_BITS +: DATA_BITS];
    end
  end

  // Each byte state launches once (pending set), then waits for the matching tx_done.
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    len_d       = len_q;
    last_d      = last_q;
    req_ready_d = '0;
    tx_start_d  = 1'b0;
    tx_data_d   = tx_data_q;
    busy_d      = busy_q;
    grant_id_d  = grant_id_q;
    truncated_d = 1'b0;
`ifdef UART_ARB_CHECKSUM_EN
    csum_d      = csum_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (arb_vld) begin
          grant_id_d = arb_idx;
          state_d    = ST_SYNC;
          busy_d     = 1'b1;
          pending_d  = 1'b0;
          len_d      = '0;
          last_d     = 1'b0;
`ifdef UART_ARB_CHECKSUM_EN
          csum_d     = '0;
`endif
        end
      end
      ST_SYNC: begin
        if (!pending_q) begin
          tx_start_d = 1'b1;
          pending_d  = 1'b1;
          tx_data_d  = SYNC_BYTE;
        end else if (tx_done) begin
          pending_d = 1'b0;
          state_d   = ST_ID;
        end
      end
      ST_ID: begin
        if (!pending_q) begin
          tx_start_d = 1'b1;
          pending_d  = 1'b1;
          tx_data_d  = id_byte;
`ifdef UART_ARB_CHECKSUM_EN
          csum_d     = csum_q ^ id_byte;
`endif
        end else if (tx_done) begin
          pending_d = 1'b0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (!pending_q) begin
          if (sel_valid) begin
            tx_start_d              = 1'b1;
            pending_d               = 1'b1;
            tx_data_d               = sel_data;
            req_ready_d[grant_id_q] = 1'b1;
            last_d                  = sel_last;
            len_d                   = len_q + 1'b1;
`ifdef UART_ARB_CHECKSUM_EN
            csum_d                  = csum_q ^ sel_data;
`endif
          end
        end else if (tx_done) begin
          pending_d = 1'b0;
          if (frame_end) begin
            truncated_d = !last_q;
`ifdef UART_ARB_CHECKSUM_EN
            state_d     = ST_CSUM;
`else
            state_d     = ST_IDLE;
            busy_d      = 1'b0;
`endif
          end
        end
      end
`ifdef UART_ARB_CHECKSUM_EN
      ST_CSUM: begin
        if (!pending_q) begin
          tx_start_d = 1'b1;
          pending_d  = 1'b1;
          tx_data_d  = csum_q;
        end else if (tx_done) begin
          pending_d = 1'b0;
          state_d   = ST_IDLE;
          busy_d    = 1'b0;
        end
      end
`endif
      default: begin
        state_d   = ST_IDLE;
        pending_d = 1'b0;
        busy_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_50MHz or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      pending_q   <= 1'b0;
      len_q       <= '0;
      last_q      <= 1'b0;
      req_ready_q <= '0;
      tx_start_q  <= 1'b0;
      tx_data_q   <= '0;
      busy_q      <= 1'b0;
      grant_id_q  <= GW'(N_REQ - 1);
      truncated_q <= 1'b0;
`ifdef UART_ARB_CHECKSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      len_q       <= len_d;
      last_q      <= last_d;
      req_ready_q <= req_ready_d;
      tx_start_q  <= tx_start_d;
      tx_data_q   <= tx_data_d;
      busy_q      <= busy_d;
      grant_id_q  <= grant_id_d;
      truncated_q <= truncated_d;
`ifdef UART_ARB_CHECKSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  assign req_ready = req_ready_q;
  assign tx_start  = tx_start_q;
  assign tx_data   = tx_data_q;
  assign busy      = busy_q;
  assign grant_id  = grant_id_q;
  assign truncated = truncated_q;

endmodule

// File: tb/tb_uart_tx_frame_arbiter.sv
// Bench for uart_tx_frame_arbiter: requester queues, transmitter model and a frame-level reference model.
module tb_uart_tx_frame_arbiter;

  localparam int NR = 3;
  localparam int DB = 8;
  localparam int ML = 4;

  logic              clk_50MHz = 1'b0;
  logic              reset;
  logic [NR-1:0]     req_valid, req_last, req_ready;
  logic [NR*DB-1:0]  req_data;
  logic              tx_start, tx_done, busy, truncated;
  logic [DB-1:0]     tx_data;
  logic [1:0]        grant_id;

  always #10 clk_50MHz = ~clk_50MHz;

  uart_tx_frame_arbiter #(.N_REQ(NR), .DATA_BITS(DB), .SYNC_BYTE(8'hA5), .MAX_LEN(ML)) dut (
    .clk_50MHz (clk_50MHz),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .tx_done   (tx_done),
    .busy      (busy),
    .grant_id  (grant_id),
    .truncated (truncated)
  );

  int total = 0;
  int bad   = 0;

  logic [8:0] rq[NR][$];          // {last, data} per requester
  logic [7:0] tx_log[$];
  int         gaps[$];
  logic [7:0] exp_q[$];
  int         exp_trunc;
  int         m_last;

  int         trunc_cnt, stab_err, rdy_err, busy_err, ovl_err;
  logic       done_busy;
  int         stall_pct;
  logic [NR-1:0] stall_hold;
  logic       inject_done;
  logic       outstanding;
  int         tx_cnt, since_done;
  logic [7:0] held;

  typedef struct packed {
    logic [1:0]  req;
    logic [3:0]  n_in;
    logic [63:0] din;
    logic [3:0]  n_exp;
    logic [95:0] dexp;
    logic [1:0]  trunc;
  } vec_t;
  vec_t vt[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk_50MHz);
    #1;
  endtask

  task automatic push(input int i, input logic [7:0] d, input logic l);
    rq[i].push_back({l, d});
  endtask

  function automatic bit queues_empty();
    for (int i = 0; i < NR; i++) if (rq[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle(input string name, input int budget);
    int n;
    int quiet;
    n = 0;
    quiet = 0;
    while (quiet < 3 && n < budget) begin
      step();
      n++;
      if (queues_empty() && !outstanding && !tx_done && !busy) quiet++;
      else quiet = 0;
    end
    if (quiet < 3) begin
      total++;
      bad++;
      $display("FAIL %s timeout: still busy after %0d cycles", name, n);
    end
  endtask

  // Frame-level reference: round-robin over non-empty queues, frames cut at last or ML bytes.
  task automatic build_model();
    logic [8:0] mq[NR][$];
    logic [8:0] e;
    logic [7:0] cs;
    logic       lst;
    int         g, c, cnt;
    for (int i = 0; i < NR; i++) mq[i] = rq[i];
    exp_q.delete();
    exp_trunc = 0;
    while (1) begin
      g = -1;
      for (int ofs = 1; ofs <= NR; ofs++) begin
        c = (m_last + ofs) % NR;
        if (g < 0 && mq[c].size() != 0) g = c;
      end
      if (g < 0) break;
      m_last = g;
      exp_q.push_back(8'hA5);
      exp_q.push_back(8'(g));
      cs  = 8'(g);
      cnt = 0;
      lst = 1'b0;
      while (!lst && cnt < ML && mq[g].size() != 0) begin
        e = mq[g].pop_front();
        exp_q.push_back(e[7:0]);
        cs  = cs ^ e[7:0];
        lst = e[8];
        cnt++;
      end
      if (!lst && cnt == ML) exp_trunc++;
`ifdef UART_ARB_CHECKSUM_EN
      exp_q.push_back(cs);
`endif
    end
  endtask

  task automatic check_log(input string name);
    int n;
    chk({name, " len"}, tx_log.size(), exp_q.size());
    n = (tx_log.size() < exp_q.size()) ? tx_log.size() : exp_q.size();
    for (int k = 0; k < n; k++) chk($sformatf("%s byte%0d", name, k), tx_log[k], exp_q[k]);
    chk({name, " trunc"}, trunc_cnt, exp_trunc);
    tx_log.delete();
    gaps.delete();
    trunc_cnt = 0;
  endtask

  // Transmitter and requester models, evaluated on the falling edge.
  initial begin
    tx_done = 1'b0; req_valid = '0; req_data = '0; req_last = '0;
    outstanding = 1'b0; tx_cnt = 0; held = '0; since_done = 0;
    trunc_cnt = 0; stab_err = 0; rdy_err = 0; busy_err = 0; ovl_err = 0; done_busy = 1'b0;
    forever begin
      @(negedge clk_50MHz);
      if (reset) begin
        tx_done = 1'b0;
        outstanding = 1'b0;
        req_valid = '0;
        since_done = 0;
      end else begin
        if (tx_done) begin
          tx_done = 1'b0;
          done_busy = busy;
        end
        since_done++;
        if (tx_start) begin
          if (outstanding) ovl_err++;
          tx_log.push_back(tx_data);
          gaps.push_back(since_done);
          held = tx_data;
          outstanding = 1'b1;
          tx_cnt = $urandom_range(2, 6);
        end else if (outstanding) begin
          if (tx_data !== held) stab_err++;
          if (!busy) busy_err++;
          tx_cnt--;
          if (tx_cnt == 0) begin
            tx_done = 1'b1;
            outstanding = 1'b0;
            since_done = 0;
          end
        end
        if (inject_done) begin
          tx_done = 1'b1;
          inject_done = 1'b0;
        end
        if (truncated) trunc_cnt++;
        if (req_ready != '0) begin
          if (!$onehot(req_ready) || !tx_start) rdy_err++;
          for (int i = 0; i < NR; i++) begin
            if (req_ready[i]) begin
              if (!req_valid[i] || rq[i].size() == 0) rdy_err++;
              else begin
                if (tx_data !== rq[i][0][7:0]) rdy_err++;
                void'(rq[i].pop_front());
              end
            end
          end
        end
        for (int i = 0; i < NR; i++) begin
          req_valid[i] = (rq[i].size() != 0) &&
                         !(busy && (stall_hold[i] || $urandom_range(0, 99) < stall_pct));
          req_data[i*DB +: DB] = (rq[i].size() != 0) ? rq[i][0][7:0] : 8'h00;
          req_last[i] = (rq[i].size() != 0) ? rq[i][0][8] : 1'b0;
        end
      end
    end
  end

  initial begin
    int  n, bad_gaps, nf, len;
    vec_t v;

`ifdef UART_ARB_CHECKSUM_EN
    vt[0] = '{req: 2'd1, n_in: 4'd2, din: 64'h4142_0000_0000_0000, n_exp: 4'd5,
              dexp: 96'hA501_4142_0200_0000_0000_0000, trunc: 2'd0};
    vt[1] = '{req: 2'd0, n_in: 4'd1, din: 64'h1000_0000_0000_0000, n_exp: 4'd4,
              dexp: 96'hA500_1010_0000_0000_0000_0000, trunc: 2'd0};
    vt[2] = '{req: 2'd2, n_in: 4'd6, din: 64'h0102_0304_0506_0000, n_exp: 4'd12,
              dexp: 96'hA502_0102_0304_06A5_0205_0601, trunc: 2'd1};
    vt[3] = '{req: 2'd0, n_in: 4'd4, din: 64'h1122_3344_0000_0000, n_exp: 4'd7,
              dexp: 96'hA500_1122_3344_4400_0000_0000, trunc: 2'd0};
`else
    vt[0] = '{req: 2'd1, n_in: 4'd2, din: 64'h4142_0000_0000_0000, n_exp: 4'd4,
              dexp: 96'hA501_4142_0000_0000_0000_0000, trunc: 2'd0};
    vt[1] = '{req: 2'd0, n_in: 4'd1, din: 64'h1000_0000_0000_0000, n_exp: 4'd3,
              dexp: 96'hA500_1000_0000_0000_0000_0000, trunc: 2'd0};
    vt[2] = '{req: 2'd2, n_in: 4'd6, din: 64'h0102_0304_0506_0000, n_exp: 4'd10,
              dexp: 96'hA502_0102_0304_A502_0506_0000, trunc: 2'd1};
    vt[3] = '{req: 2'd0, n_in: 4'd4, din: 64'h1122_3344_0000_0000, n_exp: 4'd6,
              dexp: 96'hA500_1122_3344_0000_0000_0000, trunc: 2'd0};
`endif

    reset = 1'b1; stall_pct = 0; stall_hold = '0; inject_done = 1'b0; m_last = NR - 1;
    repeat (3) step();
    chk("rst tx_start", tx_start, 0);
    chk("rst req_ready", req_ready, 0);
    chk("rst busy", busy, 0);
    chk("rst truncated", truncated, 0);
    chk("rst grant_id", grant_id, NR - 1);
    chk("rst tx_data", tx_data, 0);
    reset = 1'b0;
    step();

    // Both requesters ready straight after reset: requester 0 must win.
    push(0, 8'h10, 1'b1);
    push(1, 8'h20, 1'b1);
    build_model();
    n = 0;
    while (tx_log.size() == 0 && n < 20) begin step(); n++; end
    chk("sync latency", n, 3);
    wait_idle("first", 400);
    chk("req0 first", (tx_log.size() > 1) ? tx_log[1] : 8'hFF, 8'h00);
    check_log("first");

    for (int t = 0; t < 4; t++) begin
      v = vt[t];
      for (int k = 0; k < int'(v.n_in); k++)
        push(int'(v.req), v.din[63-8*k -: 8], k == int'(v.n_in) - 1);
      m_last = int'(v.req);
      wait_idle($sformatf("vec%0d", t), 600);
      chk($sformatf("vec%0d len", t), tx_log.size(), v.n_exp);
      for (int k = 0; k < int'(v.n_exp) && k < tx_log.size(); k++)
        chk($sformatf("vec%0d byte%0d", t, k), tx_log[k], v.dexp[95-8*k -: 8]);
      chk($sformatf("vec%0d trunc", t), trunc_cnt, v.trunc);
      chk($sformatf("vec%0d busy after done", t), done_busy, 0);
      if (v.trunc == 2'd0) begin
        bad_gaps = 0;
        for (int k = 1; k < gaps.size(); k++) if (gaps[k] != 2) bad_gaps++;
        chk($sformatf("vec%0d gaps", t), bad_gaps, 0);
      end
      tx_log.delete();
      gaps.delete();
      trunc_cnt = 0;
    end

    // Requester 0 keeps asking while requester 1 asks once.
    push(0, 8'h30, 1'b1);
    push(0, 8'h31, 1'b1);
    push(0, 8'h32, 1'b1);
    push(1, 8'h40, 1'b1);
    build_model();
    wait_idle("alternate", 800);
    check_log("alternate");

    // Spurious tx_done while idle.
    inject_done = 1'b1;
    repeat (6) step();
    chk("idle done starts", tx_log.size(), 0);
    chk("idle done busy", busy, 0);
    chk("idle done grant", grant_id, m_last);

    // Spurious tx_done while the payload is stalled.
    stall_hold[1] = 1'b1;
    push(1, 8'h55, 1'b0);
    push(1, 8'h66, 1'b1);
    build_model();
    n = 0;
    while (!(tx_log.size() == 2 && !outstanding && !tx_done) && n < 100) begin step(); n++; end
    repeat (4) step();
    inject_done = 1'b1;
    repeat (6) step();
    chk("stall starts", tx_log.size(), 2);
    chk("stall busy", busy, 1);
    chk("stall queue", rq[1].size(), 2);
    stall_hold = '0;
    wait_idle("stall", 400);
    check_log("stall");

    // Reset in the middle of a payload.
    push(0, 8'h81, 1'b0);
    push(0, 8'h82, 1'b0);
    push(0, 8'h83, 1'b0);
    push(0, 8'h84, 1'b1);
    n = 0;
    while (tx_log.size() < 3 && n < 100) begin step(); n++; end
    chk("midreset reached data", tx_log.size(), 3);
    reset = 1'b1;
    #1;
    chk("midreset tx_start", tx_start, 0);
    chk("midreset req_ready", req_ready, 0);
    chk("midreset busy", busy, 0);
    chk("midreset grant_id", grant_id, NR - 1);
    chk("midreset truncated", truncated, 0);
    chk("midreset tx_data", tx_data, 0);
    for (int i = 0; i < NR; i++) rq[i].delete();
    tx_log.delete();
    gaps.delete();
    trunc_cnt = 0;
    repeat (2) step();
    reset = 1'b0;
    m_last = NR - 1;
    step();
    push(1, 8'h77, 1'b1);
    build_model();
    wait_idle("after reset", 400);
    chk("after reset sync", (tx_log.size() > 0) ? tx_log[0] : 8'h00, 8'hA5);
    check_log("after reset");

    for (int r = 0; r < 20; r++) begin
      stall_pct = $urandom_range(0, 40);
      for (int i = 0; i < NR; i++) begin
        nf = $urandom_range(0, 2);
        for (int f = 0; f < nf; f++) begin
          len = $urandom_range(1, 6);
          for (int b = 0; b < len; b++) push(i, 8'($urandom), b == len - 1);
        end
      end
      build_model();
      wait_idle($sformatf("rand%0d", r), 5000);
      check_log($sformatf("rand%0d", r));
    end
    stall_pct = 0;

    chk("tx_data stable", stab_err, 0);
    chk("ready with start", rdy_err, 0);
    chk("busy while sending", busy_err, 0);
    chk("start overlap", ovl_err, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
